// File: rtl/axil_regbank.sv
// AXI4-Lite register bank: REG_NUM registers, read-only lanes fed from reg_in, per-register write pulses.
// Build option: define AXIL_REGBANK_STRB_EN to honour wstrb byte enables (full-word writes otherwise).
module axil_regbank #(
  parameter int                 ADDR_WIDTH = 32,
  parameter int                 DATA_WIDTH = 32,
  parameter int                 REG_NUM    = 8,
  parameter logic [REG_NUM-1:0] RO_MASK    = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  // write address
  input  logic [ADDR_WIDTH-1:0]         awaddr,
  input  logic                          awvalid,
  output logic                          awready,
  // write data
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [DATA_WIDTH/8-1:0]       wstrb,
  input  logic                          wvalid,
  output logic                          wready,
  // write response
  output logic [1:0]                    bresp,
  output logic                          bvalid,
  input  logic                          bready,
  // read address
  input  logic [ADDR_WIDTH-1:0]         araddr,
  input  logic                          arvalid,
  output logic                          arready,
  // read data
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [1:0]                    rresp,
  output logic                          rvalid,
  input  logic                          rready,
  // register side
  output logic [REG_NUM*DATA_WIDTH-1:0] reg_out,
  input  logic [REG_NUM*DATA_WIDTH-1:0] reg_in,
  output logic [REG_NUM-1:0]            wr_pulse
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int LSB        = $clog2(STRB_WIDTH);
  localparam int IDX_W      = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam int BEEF_REP   = DATA_WIDTH / 32;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  logic [DATA_WIDTH-1:0] regs_q [REG_NUM];

  // One-entry holding buffers for the independent AW and W channels
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic                  aw_full_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic                  w_full_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic commit;
  logic aw_full_d, w_full_d;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid  && wready;
  assign b_hs  = bvalid  && bready;
  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid  && rready;

  // A commit needs both halves and a free (or draining) response slot
  assign commit    = aw_full_q && w_full_q && (!bvalid || bready);
  assign aw_full_d = commit ? 1'b0 : (aw_full_q || aw_hs);
  assign w_full_d  = commit ? 1'b0 : (w_full_q  || w_hs);

  // ---------------------------------------------------------------------------
  // Write address decode
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] wr_word;
  logic [IDX_W-1:0]      wr_idx;
  logic                  wr_in_range;
  logic                  wr_ro;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;

  assign wr_word     = aw_addr_q >> LSB;
  assign wr_idx      = wr_word[IDX_W-1:0];
  assign wr_in_range = wr_word < ADDR_WIDTH'(REG_NUM);
  assign wr_ro       = wr_in_range && RO_MASK[wr_idx];
  assign wr_en       = commit && wr_in_range && !wr_ro;

`ifdef AXIL_REGBANK_STRB_EN
  logic [STRB_WIDTH-1:0] w_strb_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_data = regs_q[wr_idx];
    for (int b = 0; b < STRB_WIDTH; b++) begin
      if (w_strb_q[b]) wr_data[b*8 +: 8] = w_data_q[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    w_strb_q <= '0;
    else if (w_hs) w_strb_q <= wstrb;
  end
`else
  logic strb_unused;

  assign strb_unused = ^wstrb;
  assign wr_data     = w_data_q;
`endif

  // ---------------------------------------------------------------------------
  // Write channels, response and register storage
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_addr_q <= '0;
      aw_full_q <= 1'b0;
      w_data_q  <= '0;
      w_full_q  <= 1'b0;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      wr_pulse  <= '0;
      // NOTE: the register array is reset because reg_out exposes every entry to hardware.
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
    end else begin
      if (aw_hs) aw_addr_q <= awaddr;
      if (w_hs)  w_data_q  <= wdata;
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      awready   <= !aw_full_d;
      wready    <= !w_full_d;

      wr_pulse <= '0;
      if (wr_en) begin
        regs_q[wr_idx]   <= wr_data;
        wr_pulse[wr_idx] <= 1'b1;
      end

      // A commit on the B handshake edge keeps bvalid high with the new response
      if (commit) begin
        bvalid <= 1'b1;
        bresp  <= (wr_in_range && !wr_ro) ? RESP_OKAY : RESP_SLVERR;
      end else if (b_hs) begin
        bvalid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel: single outstanding read, data captured on the AR handshake
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] rd_word;
  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_in_range;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [1:0]            rd_resp;

  assign rd_word     = araddr >> LSB;
  assign rd_idx      = rd_word[IDX_W-1:0];
  assign rd_in_range = rd_word < ADDR_WIDTH'(REG_NUM);

  always_comb begin
    rd_data = {BEEF_REP{32'hDEAD_BEEF}};
    rd_resp = RESP_SLVERR;
    if (rd_in_range) begin
      rd_resp = RESP_OKAY;
      if (RO_MASK[rd_idx]) rd_data = reg_in[int'(rd_idx)*DATA_WIDTH +: DATA_WIDTH];
      else                 rd_data = regs_q[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid  <= 1'b1;
      arready <= 1'b0;
      rdata   <= rd_data;
      rresp   <= rd_resp;
    end else if (r_hs) begin
      rvalid  <= 1'b0;
      arready <= 1'b1;
    end else begin
      arready <= !rvalid;
    end
  end

  for (genvar g = 0; g < REG_NUM; g++) begin : g_reg_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_axil_regbank.sv
// Directed bench for axil_regbank (8 x 32-bit, register 2 read-only) with response scoreboards.
module tb_axil_regbank;

  localparam int              AW = 32;
  localparam int              DW = 32;
  localparam int              RN = 8;
  localparam logic [RN-1:0]   RO = 8'b0000_0100;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   awaddr, araddr;
  logic            awvalid, wvalid, bready, arvalid, rready;
  logic            awready, wready, bvalid, arready, rvalid;
  logic [DW-1:0]   wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0]      bresp, rresp;
  logic [RN*DW-1:0] reg_out, reg_in;
  logic [RN-1:0]   wr_pulse;

  axil_regbank #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_NUM(RN), .RO_MASK(RO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  int          errors = 0;
  int          checks = 0;
  logic [1:0]  exp_b [$];
  rd_exp_t     exp_r [$];
  logic [31:0] model [RN];
  logic [RN-1:0] pulse_seen = '0;
  int          pulse_cycles = 0;

  always @(posedge clk) begin
    #1;
    if (wr_pulse != '0) begin
      pulse_seen |= wr_pulse;
      pulse_cycles++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void write_model(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb,
                                      output logic [1:0] resp, output logic [RN-1:0] mask);
    logic [31:0] word = addr >> 2;
    logic [3:0]  eff  = strb;
`ifndef AXIL_REGBANK_STRB_EN
    eff = 4'hF;
`endif
    resp = 2'b10;
    mask = '0;
    if (word < RN && !RO[word[2:0]]) begin
      resp = 2'b00;
      mask = RN'(1) << word[2:0];
      for (int b = 0; b < 4; b++)
        if (eff[b]) model[word[2:0]][b*8 +: 8] = data[b*8 +: 8];
    end
  endfunction

  function automatic rd_exp_t exp_read(input logic [31:0] addr);
    logic [31:0] word = addr >> 2;
    rd_exp_t e;
    e.data = 32'hDEAD_BEEF;
    e.resp = 2'b10;
    if (word < RN) begin
      e.resp = 2'b00;
      e.data = RO[word[2:0]] ? reg_in[word[2:0]*DW +: DW] : model[word[2:0]];
    end
    return e;
  endfunction

  function automatic logic [1:0] pop_b();
    logic [1:0] v = 2'bxx;
    if (exp_b.size() > 0) v = exp_b.pop_front();
    return v;
  endfunction

  function automatic rd_exp_t pop_r();
    rd_exp_t v = '{data: 32'hxxxx_xxxx, resp: 2'bxx};
    if (exp_r.size() > 0) v = exp_r.pop_front();
    return v;
  endfunction

  task automatic send_aw_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    while (!(awready && wready) && n < 50) begin @(negedge clk); n++; end
    check("aw_w_ready", awready && wready, 1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic get_b(input string tag);
    int n = 0;
    bready = 1'b1;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    check({tag, "_bvalid"}, bvalid, 1);
    check({tag, "_bresp"}, bresp, pop_b());
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    logic [1:0]    r;
    logic [RN-1:0] m;
    write_model(addr, data, strb, r, m);
    exp_b.push_back(r);
    pulse_seen = '0; pulse_cycles = 0;
    send_aw_w(addr, data, strb);
    get_b(tag);
    check({tag, "_pulse"}, pulse_seen, m);
    check({tag, "_pulse_cycles"}, pulse_cycles, (m != '0) ? 1 : 0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr);
    int n = 0;
    rd_exp_t e;
    exp_r.push_back(exp_read(addr));
    araddr = addr; arvalid = 1'b1;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    check({tag, "_arready"}, arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    check({tag, "_rvalid"}, rvalid, 1);
    e = pop_r();
    check({tag, "_rdata"}, rdata, e.data);
    check({tag, "_rresp"}, rresp, e.resp);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check({tag, "_rvalid_clr"}, rvalid, 0);
    check({tag, "_arready_back"}, arready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]    r, held;
    logic [RN-1:0] m;
    rd_exp_t       e;
    int            n;

    rst_n = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < RN; i++) reg_in[i*DW +: DW] = 32'h1000_0000 + i;
    reg_in[2*DW +: DW] = 32'h0000_CAFE;
    for (int i = 0; i < RN; i++) model[i] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_reg_out", reg_out[63:0] | reg_out[255:192], 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {awready, wready, arready}, 3'b111);

    // AW and W on the same edge: bvalid exactly one edge later
    write_model(32'h04, 32'hA5A5_1234, 4'hF, r, m);
    exp_b.push_back(r);
    pulse_seen = '0; pulse_cycles = 0;
    awaddr = 32'h04; wdata = 32'hA5A5_1234; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("lat_bvalid_e0", bvalid, 0);
    check("lat_ready_low", {awready, wready}, 2'b00);
    @(negedge clk);
    check("lat_bvalid_e1", bvalid, 1);
    check("lat_bresp", bresp, pop_b());
    check("lat_wr_pulse", wr_pulse, m);
    check("lat_reg_out1", reg_out[1*DW +: DW], model[1]);
    check("lat_ready_back", {awready, wready}, 2'b11);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("lat_bvalid_clr", bvalid, 0);
    check("lat_pulse_one", pulse_cycles, 1);
    do_read("rd_reg1", 32'h04);

    // Read and commit to the same register on one edge return the old value
    exp_r.push_back(exp_read(32'h04));
    write_model(32'h04, 32'h5555_AAAA, 4'hF, r, m);
    exp_b.push_back(r);
    awaddr = 32'h04; wdata = 32'h5555_AAAA; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("rw_same_arready", arready, 1);
    araddr = 32'h04; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    e = pop_r();
    check("rw_same_rvalid", rvalid, 1);
    check("rw_same_rdata_old", rdata, e.data);
    check("rw_same_bvalid", bvalid, 1);
    check("rw_same_bresp", bresp, pop_b());
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    do_read("rd_reg1_new", 32'h04);

    // W three cycles ahead of AW, bready held low, second write buffered meanwhile
    write_model(32'h0C, 32'h0BAD_F00D, 4'hF, r, m);
    exp_b.push_back(r);
    pulse_seen = '0; pulse_cycles = 0;
    wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    check("early_w_wready_low", wready, 0);
    repeat (2) @(negedge clk);
    check("early_w_no_commit", bvalid, 0);
    check("early_w_awready", awready, 1);
    awaddr = 32'h0C; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check("early_w_bvalid_e0", bvalid, 0);
    @(negedge clk);
    check("early_w_bvalid", bvalid, 1);
    held = pop_b();
    check("early_w_bresp", bresp, held);
    check("early_w_ready_back", {awready, wready}, 2'b11);
    write_model(32'h08, 32'h1234_5678, 4'hF, r, m);
    exp_b.push_back(r);
    awaddr = 32'h08; wdata = 32'h1234_5678; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("pend_buffered", {awready, wready}, 2'b00);
    for (int i = 0; i < 3; i++) begin
      check("pend_bvalid_hold", bvalid, 1);
      check("pend_bresp_stable", bresp, held);
      @(negedge clk);
    end
    check("pend_bvalid_hold4", bvalid, 1);
    bready = 1'b1;
    @(negedge clk);
    check("b2b_bvalid_kept", bvalid, 1);
    check("b2b_bresp_new", bresp, pop_b());
    check("b2b_ready_back", {awready, wready}, 2'b11);
    @(negedge clk);
    bready = 1'b0;
    check("b2b_bvalid_clr", bvalid, 0);
    check("b2b_pulse_only3", pulse_seen, 8'h08);
    check("b2b_single_commit", pulse_cycles, 1);
    check("b2b_reg_out3", reg_out[3*DW +: DW], model[3]);

    // Read-only register
    do_write("wr_ro", 32'h08, 32'hFFFF_0000, 4'hF);
    check("ro_reg_out2", reg_out[2*DW +: DW], model[2]);
    do_read("rd_ro", 32'h08);

    // Range boundaries and ignored byte-lane bits
    do_read("rd_oor", 32'h40);
    do_write("wr_oor", 32'h40, 32'h9999_9999, 4'hF);
    do_write("wr_last", 32'h1C, 32'hC0DE_0007, 4'hF);
    do_read("rd_last_lane", 32'h1F);
    do_read("rd_oor_3c", 32'h3C);

    // Byte strobes
    do_write("wr_reg0", 32'h00, 32'h1122_3344, 4'hF);
    do_write("wr_strb", 32'h00, 32'hFFFF_FFFF, 4'b0101);
    do_read("rd_strb", 32'h00);
    do_write("wr_strb0", 32'h00, 32'h0000_0000, 4'b0000);
    do_read("rd_strb0", 32'h00);

    // Reset with a pending B response and a buffered AW
    write_model(32'h14, 32'hDEAD_0001, 4'hF, r, m);
    exp_b.push_back(r);
    send_aw_w(32'h14, 32'hDEAD_0001, 4'hF);
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    check("mid_bvalid", bvalid, 1);
    awaddr = 32'h18; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check("mid_aw_buffered", awready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {awready, wready, arready}, 3'b000);
    check("mid_rst_valid", {bvalid, rvalid}, 2'b00);
    check("mid_rst_resp", {bresp, rresp}, 4'b0000);
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_pulse", wr_pulse, 0);
    check("mid_rst_regs_lo", reg_out[127:0], 0);
    check("mid_rst_regs_hi", reg_out[255:128], 0);
    exp_b.delete();
    for (int i = 0; i < RN; i++) model[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    pulse_seen = '0; pulse_cycles = 0;
    @(negedge clk);
    check("mid_rel_ready", {awready, wready}, 2'b11);
    wdata = 32'h0000_0077; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_no_commit", bvalid, 0);
    check("mid_no_pulse", pulse_cycles, 0);
    check("mid_regs_zero", reg_out[191:0], 0);
    write_model(32'h18, 32'h0000_0077, 4'hF, r, m);
    exp_b.push_back(r);
    awaddr = 32'h18; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    check("mid_aw_ready", awready, 1);
    @(negedge clk);
    awvalid = 1'b0;
    get_b("mid_after");
    check("mid_after_pulse", pulse_seen, m);
    do_read("rd_mid_r5", 32'h14);
    do_read("rd_mid_r6", 32'h18);

    check("sb_b_empty", exp_b.size(), 0);
    check("sb_r_empty", exp_r.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
